// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the MIPS-R2000 instruction-decode stage:
//   - bit positions of the R/I-type instruction fields
//   - REG_ZERO, the hard-wired zero register index
//   - id_bundle_t, the decoded ID/EX bundle at the default 32-bit / 32-register
//     configuration (the parametrised top builds its own width-matched copy)
// -----------------------------------------------------------------------------
package id_pkg;

  localparam int INST_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int REG_FIELD_W = 5;

  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = FUNCT_MSB - FUNCT_LSB + 1;

  localparam int REG_ZERO   = 0;

  // Default-configuration bundle widths
  localparam int ID_DATA_W  = 32;
  localparam int ID_ADDR_W  = 5;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [FUNCT_W-1:0]   funct;
    logic [ID_ADDR_W-1:0] rs;
    logic [ID_ADDR_W-1:0] rt;
    logic [ID_ADDR_W-1:0] rd;
    logic [ID_DATA_W-1:0] imm;
    logic [ID_DATA_W-1:0] data_1;
    logic [ID_DATA_W-1:0] data_2;
  } id_bundle_t;

endpackage

// File: rtl/id_regfile_pipe_regfile.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Architectural register file: two combinational read ports, one synchronous
// write port. Register 0 always reads zero and ignores writes.
//
// Optional build macro: ID_WB_BYPASS_EN
//   defined   - a read of the register being written this cycle returns wr_data
//   undefined - the read returns the value stored before the write
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rd_addr_1 / rd_data_1  read port 1
//   rd_addr_2 / rd_data_2  read port 2
//   wr_en, wr_addr, wr_data write port (ignored while rst is high)
// Reset contents: register i = i when INIT_INDEX=1, otherwise all zero.
// -----------------------------------------------------------------------------
module regfile_2r1w
  import id_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int NREGS      = 32,
  parameter  int INIT_INDEX = 1,
  localparam int ADDR_W     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != ZERO_IDX);

  // Write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports
  always_comb begin
    rd_data_1 = regs[rd_addr_1];
    rd_data_2 = regs[rd_addr_2];
`ifdef ID_WB_BYPASS_EN
    if (wr_live && (wr_addr == rd_addr_1)) rd_data_1 = wr_data;
    if (wr_live && (wr_addr == rd_addr_2)) rd_data_2 = wr_data;
`endif
    // Storage for register 0 is never written, but force zero so the read
    // value never depends on it.
    if (rd_addr_1 == ZERO_IDX) rd_data_1 = '0;
    if (rd_addr_2 == ZERO_IDX) rd_data_2 = '0;
  end

endmodule

// File: rtl/id_regfile_pipe.sv
// -----------------------------------------------------------------------------
// id_regfile_pipe
// MIPS-R2000 decode stage: splits the instruction into fields, extends the
// 16-bit immediate, reads rs/rt from the integrated register file and registers
// the decoded bundle into the ID/EX register with a valid/ready handshake,
// stall and flush.
//
// Optional build macro: ID_WB_BYPASS_EN (write-through of a same-cycle
// writeback into the operand read; see regfile_2r1w).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready / inst_in upstream handshake and instruction word
//   flush                         kill held/incoming bundle
//   wb_en / wb_addr / wb_data     register writeback
//   out_valid / out_ready         downstream handshake
//   out_opcode, out_funct         inst[31:26], inst[5:0]
//   out_rs, out_rt, out_rd        register indices (low ADDR_W bits)
//   out_imm                       extended immediate
//   out_data_1, out_data_2        operands read at rs and rt
// -----------------------------------------------------------------------------
module id_regfile_pipe
  import id_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int NREGS      = 32,
  parameter  int IMM_SIGNED = 1,
  parameter  int INIT_INDEX = 1,
  localparam int ADDR_W     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   inst_in,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [FUNCT_W-1:0]  out_funct,
  output logic [ADDR_W-1:0]   out_rs,
  output logic [ADDR_W-1:0]   out_rt,
  output logic [ADDR_W-1:0]   out_rd,
  output logic [DATA_W-1:0]   out_imm,
  output logic [DATA_W-1:0]   out_data_1,
  output logic [DATA_W-1:0]   out_data_2
);

  if (DATA_W < IMM_W) begin : g_bad_data_w
    $error("DATA_W must be at least 16");
  end
  if ((NREGS < 2) || (NREGS > 32) || ((1 << ADDR_W) != NREGS)) begin : g_bad_nregs
    $error("NREGS must be a power of two in 2..32");
  end

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic [ADDR_W-1:0]   rs;
    logic [ADDR_W-1:0]   rt;
    logic [ADDR_W-1:0]   rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   data_1;
    logic [DATA_W-1:0]   data_2;
  } bundle_t;

  // Sign- or zero-extend the immediate; a size cast of a signed operand
  // replicates its MSB, which also works at DATA_W == 16.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm);
    logic signed [IMM_W-1:0] imm_s;
    imm_s = imm;
    if (IMM_SIGNED != 0) return DATA_W'(imm_s);
    return DATA_W'(imm);
  endfunction

  bundle_t           bundle_p0;
  bundle_t           bundle_p1;
  logic              vld_p1;
  logic              take_p0;
  logic              stall_p1;
  logic              wb_live;
  logic [DATA_W-1:0] rd_data_1_p0;
  logic [DATA_W-1:0] rd_data_2_p0;

  // ---- Stage p0: field extraction, immediate extension, operand read ----
  always_comb begin
    bundle_p0        = '0;
    bundle_p0.opcode = inst_in[OPCODE_MSB:OPCODE_LSB];
    bundle_p0.funct  = inst_in[FUNCT_MSB:FUNCT_LSB];
    bundle_p0.rs     = inst_in[RS_LSB +: ADDR_W];
    bundle_p0.rt     = inst_in[RT_LSB +: ADDR_W];
    bundle_p0.rd     = inst_in[RD_LSB +: ADDR_W];
    bundle_p0.imm    = extend_imm(inst_in[IMM_MSB:IMM_LSB]);
    bundle_p0.data_1 = rd_data_1_p0;
    bundle_p0.data_2 = rd_data_2_p0;
  end

  regfile_2r1w #(
    .DATA_W     (DATA_W),
    .NREGS      (NREGS),
    .INIT_INDEX (INIT_INDEX)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_1 (bundle_p0.rs),
    .rd_data_1 (rd_data_1_p0),
    .rd_addr_2 (bundle_p0.rt),
    .rd_data_2 (rd_data_2_p0),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign take_p0  = in_valid && in_ready;
  assign stall_p1 = vld_p1 && !out_ready;
  assign wb_live  = wb_en && (wb_addr != ZERO_IDX);

  // ---- Stage p1: ID/EX pipeline register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (take_p0) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= bundle_p0;
    end else if (stall_p1) begin
      // A held bundle must not go stale: pick up writebacks to its sources.
      if (wb_live && (wb_addr == bundle_p1.rs)) bundle_p1.data_1 <= wb_data;
      if (wb_live && (wb_addr == bundle_p1.rt)) bundle_p1.data_2 <= wb_data;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_opcode = bundle_p1.opcode;
  assign out_funct  = bundle_p1.funct;
  assign out_rs     = bundle_p1.rs;
  assign out_rt     = bundle_p1.rt;
  assign out_rd     = bundle_p1.rd;
  assign out_imm    = bundle_p1.imm;
  assign out_data_1 = bundle_p1.data_1;
  assign out_data_2 = bundle_p1.data_2;

endmodule
